// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor with mtime/mtimecmp/msip behind a one-cycle valid/ready slave port
module clint_timer #(
  parameter int unsigned RTC_DIV = 1,
  parameter logic [31:0] BASE    = 32'h0200_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam logic [15:0] DIV_M1 = 16'(RTC_DIV - 1);
  state_t state_q, state_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d, off_full, rd;
  logic [15:0] presc_q, presc_d, off;
  logic msip_reg_q, msip_reg_d, mtip_q, mtip_d, msip_q, msip_d;
  logic acc, wr, tick, wr_lo, wr_hi, unused_ok;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
    return m;
  endfunction
  assign off_full  = mem_addr - BASE;
  assign unused_ok = ^{mem_instr, off_full[31:16]};
  always_comb begin
    off        = off_full[15:0];
    acc        = mem_valid && state_q == IDLE;
    wr         = acc && |mem_wstrb;
    tick       = presc_q == DIV_M1;
    wr_lo      = wr && off == 16'hBFF8;
    wr_hi      = wr && off == 16'hBFFC;
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = (wr_lo || wr_hi) ? {wr_hi ? merge(mtime_q[63:32], mem_wdata, mem_wstrb) : mtime_q[63:32],
                                     wr_lo ? merge(mtime_q[31:0], mem_wdata, mem_wstrb) : mtime_q[31:0]}
               : tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = {(wr && off == 16'h4004) ? merge(mtimecmp_q[63:32], mem_wdata, mem_wstrb) : mtimecmp_q[63:32],
                  (wr && off == 16'h4000) ? merge(mtimecmp_q[31:0], mem_wdata, mem_wstrb) : mtimecmp_q[31:0]};
    msip_reg_d = (wr && off == 16'h0000 && mem_wstrb[0]) ? mem_wdata[0] : msip_reg_q;
    rd         = off == 16'h0000 ? {31'd0, msip_reg_q}
               : off == 16'h4000 ? mtimecmp_q[31:0]
               : off == 16'h4004 ? mtimecmp_q[63:32]
               : off == 16'hBFF8 ? mtime_q[31:0]
               : off == 16'hBFFC ? mtime_q[63:32] : 32'd0;
    rdata_d    = (acc && !(|mem_wstrb)) ? rd : 32'd0;
    state_d    = acc ? RESP : IDLE;
    mtip_d     = mtime_q >= mtimecmp_q;
    msip_d     = msip_reg_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      msip_reg_q <= 1'b0;
      rdata_q    <= '0;
      mtip_q     <= 1'b0;
      msip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      msip_reg_q <= msip_reg_d;
      rdata_q    <= rdata_d;
      mtip_q     <= mtip_d;
      msip_q     <= msip_d;
    end
  end
  assign mem_ready = state_q == RESP && reset;
  assign mem_rdata = reset ? rdata_q : 32'd0;
  assign mtip      = mtip_q;
  assign msip      = msip_q;
  assign mtime     = mtime_q;
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: randomized and directed checks of two clint_timer instances (RTC_DIV 1 and 4) against a spec model
module tb_clint_timer;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic clock, reset, mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [31:0] rdata [2];
  logic ready [2], mtip_o [2], msip_o [2];
  logic [63:0] mtime_o [2];
  int total = 0, bad = 0;
  logic [63:0] m_time [2];
  logic [63:0] m_cmp;
  logic m_sip, e_ready, e_rd, e_msip;
  logic e_mtip [2];
  logic [31:0] e_rdata [2];
  int unsigned cyc;
  clint_timer #(.RTC_DIV(1), .BASE(BASE)) dut1 (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata[0]), .mem_ready(ready[0]), .mtip(mtip_o[0]), .msip(msip_o[0]), .mtime(mtime_o[0]));
  clint_timer #(.RTC_DIV(4), .BASE(BASE)) dut4 (
    .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata[1]), .mem_ready(ready[1]), .mtip(mtip_o[1]), .msip(msip_o[1]), .mtime(mtime_o[1]));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  function automatic int unsigned div(input int k);
    return k == 0 ? 1 : 4;
  endfunction
  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (d & mask);
  endfunction
  function automatic logic [31:0] readval(input logic [15:0] o, input int k);
    if (o == 16'h0000) return {31'd0, m_sip};
    if (o == 16'h4000) return m_cmp[31:0];
    if (o == 16'h4004) return m_cmp[63:32];
    if (o == 16'hBFF8) return m_time[k][31:0];
    if (o == 16'hBFFC) return m_time[k][63:32];
    return 32'd0;
  endfunction
  always @(posedge clock) begin
    logic [15:0] o;
    logic acc, w;
    if (!reset) begin
      cyc <= 0;
      m_cmp <= '1;
      m_sip <= 1'b0;
      e_ready <= 1'b0;
      e_rd <= 1'b0;
      e_msip <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_time[k] <= '0;
        e_mtip[k] <= 1'b0;
        e_rdata[k] <= '0;
      end
    end else begin
      o = 16'(mem_addr - BASE);
      acc = mem_valid && !e_ready;
      w = acc && mem_wstrb != 4'd0;
      e_ready <= acc;
      e_rd <= acc && mem_wstrb == 4'd0;
      e_msip <= m_sip;
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
        e_mtip[k] <= m_time[k] >= m_cmp;
        e_rdata[k] <= (acc && mem_wstrb == 4'd0) ? readval(o, k) : 32'd0;
        if (w && o == 16'hBFF8) m_time[k] <= {m_time[k][63:32], lanes(m_time[k][31:0], mem_wdata, mem_wstrb)};
        else if (w && o == 16'hBFFC) m_time[k] <= {lanes(m_time[k][63:32], mem_wdata, mem_wstrb), m_time[k][31:0]};
        else if (cyc % div(k) == div(k) - 1) m_time[k] <= m_time[k] + 64'd1;
      end
      if (w && o == 16'h0000 && mem_wstrb[0]) m_sip <= mem_wdata[0];
      if (w && o == 16'h4000) m_cmp[31:0] <= lanes(m_cmp[31:0], mem_wdata, mem_wstrb);
      if (w && o == 16'h4004) m_cmp[63:32] <= lanes(m_cmp[63:32], mem_wdata, mem_wstrb);
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("mtime%0d", k), mtime_o[k], m_time[k]);
      chk($sformatf("mtip%0d", k), mtip_o[k], e_mtip[k]);
      chk($sformatf("msip%0d", k), msip_o[k], e_msip);
      chk($sformatf("ready%0d", k), ready[k], e_ready && reset);
      if (!(e_ready && !e_rd)) chk($sformatf("rdata%0d", k), rdata[k], (e_ready && reset) ? e_rdata[k] : 32'd0);
    end
  endtask
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic hold,
                        output logic [31:0] r, output logic rdy);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = 1'($urandom);
    step();
    r = rdata[0];
    rdy = ready[0];
    mem_valid = hold;
    step();
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
  endtask
  initial begin
    logic [31:0] r;
    logic rdy, seen;
    logic [31:0] a, d;
    logic [3:0] s;
    reset = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    repeat (3) step();
    chk("rst_mtime", mtime_o[0], 64'd0);
    chk("rst_mtip", mtip_o[0], 1'b0);
    chk("rst_msip", msip_o[1], 1'b0);
    chk("rst_ready", ready[0], 1'b0);
    reset = 1'b1;
    step();
    chk("first_tick", mtime_o[0], 64'd1);
    repeat (39) step();
    chk("div4_40cyc", mtime_o[1], 64'd10);
    chk("div1_40cyc", mtime_o[0], 64'd40);
    access(BASE + 32'h4004, 0, 4'd0, 1'b0, r, rdy);
    chk("cmp_hi_rst", r, 32'hFFFF_FFFF);
    chk("cmp_hi_rdy", rdy, 1'b1);
    access(BASE + 32'hBFF8, 0, 4'hF, 1'b0, r, rdy);
    access(BASE + 32'hBFFC, 0, 4'hF, 1'b0, r, rdy);
    access(BASE + 32'h4004, 0, 4'hF, 1'b0, r, rdy);
    access(BASE + 32'h4000, 20, 4'hF, 1'b0, r, rdy);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mtime_o[0] == 64'd20) chk("mtip_at20", mtip_o[0], 1'b0);
      if (mtime_o[0] == 64'd21) begin
        chk("mtip_at21", mtip_o[0], 1'b1);
        seen = 1'b1;
      end
    end
    chk("reach21", seen, 1'b1);
    repeat (5) step();
    chk("mtip_stays", mtip_o[0], 1'b1);
    access(BASE + 32'h4000, 1000, 4'hF, 1'b0, r, rdy);
    chk("mtip_clear", mtip_o[0], 1'b0);
    access(BASE, 32'hFFFF_FFFF, 4'b0001, 1'b0, r, rdy);
    chk("msip_set", msip_o[0], 1'b1);
    access(BASE, 0, 4'd0, 1'b0, r, rdy);
    chk("msip_read", r, 32'd1);
    access(BASE, 0, 4'b0010, 1'b0, r, rdy);
    chk("msip_keep", msip_o[1], 1'b1);
    access(BASE + 32'h4000, 5, 4'hF, 1'b0, r, rdy);
    access(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, r, rdy);
    access(BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 1'b0, r, rdy);
    chk("wrap_ff", mtime_o[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_mtip_pre", mtip_o[0], 1'b1);
    step();
    chk("wrap_zero", mtime_o[0], 64'd0);
    chk("wrap_mtip_hold", mtip_o[0], 1'b1);
    step();
    chk("wrap_one", mtime_o[0], 64'd1);
    chk("wrap_mtip_clr", mtip_o[0], 1'b0);
    access(BASE + 32'h1234, 32'hDEAD_BEEF, 4'd0, 1'b0, r, rdy);
    chk("unmap_rdata", r, 32'd0);
    chk("unmap_rdy", rdy, 1'b1);
    chk("unmap_once", ready[0], 1'b0);
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 6))
        0: a = BASE;
        1: a = BASE + 32'h4000;
        2: a = BASE + 32'h4004;
        3: a = BASE + 32'hBFF8;
        4: a = BASE + 32'hBFFC;
        5: a = BASE + {16'd0, 14'($urandom), 2'b00};
        default: a = $urandom;
      endcase
      s = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
      d = $urandom;
      if (a == BASE + 32'h4000) d = m_time[0][31:0] + 32'($urandom_range(0, 30)) - 32'd10;
      if (a == BASE + 32'h4004 || a == BASE + 32'hBFFC) d = $urandom_range(0, 1) ? m_time[0][63:32] : d;
      access(a, d, s, 1'($urandom_range(0, 3) == 0), r, rdy);
      repeat ($urandom_range(0, 3)) step();
    end
    mem_valid = 1'b1;
    mem_addr = BASE + 32'hBFF8;
    mem_wstrb = 4'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_valid = 1'b0;
    step();
    chk("rst_resp_rdy", ready[0], 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("rst2_mtime1", mtime_o[0], 64'd1);
    chk("rst2_mtime4", mtime_o[1], 64'd0);
    chk("rst2_msip", msip_o[0], 1'b0);
    access(BASE + 32'h4000, 0, 4'd0, 1'b0, r, rdy);
    chk("rst2_cmp_lo", r, 32'hFFFF_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
